// File: rtl/reg16_wr_arbiter.sv
// Round-robin write arbiter that shares one clock-enabled register bank among NREQ requesters.
// Each requester uses a 4-phase REQ/ACK handshake. The arbiter drives the bank CE/D and counts commits.
module reg16_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                  CK,
    input  logic                  CLRN,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] WD,
    output logic [NREQ-1:0]       ACK,
    output logic [IDW-1:0]        GNT_ID,
    output logic                  BUSY,
    output logic                  REG_CE,
    output logic [WIDTH-1:0]      REG_D,
    output logic [15:0]           WR_CNT
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ) begin : g_bad_params
        $error("reg16_wr_arbiter: NREQ must be 2..8 and 2**IDW >= NREQ");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0]   reg_d_q, reg_d_d;
    logic               reg_ce_q, reg_ce_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    above_ptr;
    logic [NREQ-1:0]    req_hi;
    logic [IDW-1:0]     win_lo;
    logic [IDW-1:0]     win_hi;
    logic [IDW-1:0]     winner;
    logic [WIDTH-1:0]   win_data;
    logic               gnt_req;
    logic [NREQ-1:0]    gnt_onehot;

    // Rotating priority: requests above ptr win first, else the lowest set request wraps around.
    // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
    always_comb begin
        above_ptr  = '0;
        win_lo     = '0;
        win_hi     = '0;
        win_data   = '0;
        gnt_req    = 1'b0;
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            above_ptr[i] = (i > int'(ptr_q));
        end
        req_hi = REQ & above_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (REQ[i])    win_lo = i[IDW-1:0];
            if (req_hi[i]) win_hi = i[IDW-1:0];
        end
        winner = (|req_hi) ? win_hi : win_lo;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == i[IDW-1:0]) win_data = WD[i*WIDTH +: WIDTH];
            if (gnt_id_q == i[IDW-1:0]) begin
                gnt_req       = REQ[i];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        reg_d_d  = reg_d_q;
        reg_ce_d = 1'b0;
        ack_d    = ack_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                ack_d = '0;
                if (|REQ) begin
                    gnt_id_d = winner;
                    ptr_d    = winner;
                    reg_d_d  = win_data;
                    reg_ce_d = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                // The bank captures REG_D on this edge, so the write is committed here.
                ack_d    = gnt_onehot;
                wr_cnt_d = wr_cnt_q + 16'd1;
                state_d  = S_ACK;
            end
            S_ACK: begin
                if (!gnt_req) begin
                    ack_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            state_q  <= S_IDLE;
            ptr_q    <= IDW'(NREQ - 1);
            gnt_id_q <= '0;
            reg_d_q  <= '0;
            reg_ce_q <= 1'b0;
            ack_q    <= '0;
            wr_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            reg_d_q  <= reg_d_d;
            reg_ce_q <= reg_ce_d;
            ack_q    <= ack_d;
            wr_cnt_q <= wr_cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign ACK    = ack_q;
    assign GNT_ID = gnt_id_q;
    assign BUSY   = busy_q;
    assign REG_CE = reg_ce_q;
    assign REG_D  = reg_d_q;
    assign WR_CNT = wr_cnt_q;

endmodule
